jk_input_conditioner: RTL and testbench

//   Upstream stage of the lab JK flip-flop. It turns two raw, bouncy pushbuttons (J, K) into clean
//   one-cycle J/K command pulses on the flip-flop's clock.
//   - A lone J press produces set (10); a lone K press produces reset (01).
//   - Both presses within PAIR_WINDOW cycles of each other produce toggle (11).
//   - Idle output is 00, which the flip-flop treats as hold.

---
 rtl/jk_input_conditioner.sv | 135 +++++++++++++
 tb/tb_jk_input_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_input_conditioner.sv
// rtl/jk_input_conditioner.sv - debounced J/K pushbuttons to one-cycle JK command pulses
module jk_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PAIR_WINDOW     = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_j,
   input  logic btn_k,
   output logic j_out,
   output logic k_out,
   output logic cmd_valid,
   output logic db_j,
   output logic db_k
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int WW = (PAIR_WINDOW > 1) ? $clog2(PAIR_WINDOW) : 1;

   // The counter flips db on the edge where it would otherwise reach DEBOUNCE_CYCLES.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [WW-1:0] WIN_INIT = WW'(PAIR_WINDOW - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT_J = 2'd1;
   localparam logic [1:0] ST_WAIT_K = 2'd2;
   localparam logic [1:0] ST_FIRE   = 2'd3;

   // Bit 1 carries J, bit 0 carries K throughout.
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    db;
   logic [1:0]    db_d;
   logic [CW-1:0] cnt [2];
   logic [1:0]    press;

   logic [1:0]    state;
   logic [1:0]    cmd;
   logic [WW-1:0] win;

   // Two-flop synchronizer, per-button debounce counter and one-cycle delayed debounced level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         db     <= '0;
         db_d   <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         sync1 <= {btn_j, btn_k};
         sync2 <= sync1;
         db_d  <= db;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] != db[i]) begin
               if (cnt[i] == CNT_LAST) begin
                  db[i]  <= ~db[i];
                  cnt[i] <= '0;
               end else begin
                  cnt[i] <= cnt[i] + 1'b1;
               end
            end else begin
               // Any return to the current level restarts the count, so short glitches never flip db.
               cnt[i] <= '0;
            end
         end
      end
   end

   // Only rising debounced edges count as presses; releases are ignored.
   assign press = db & ~db_d;

   // Pairing FSM: wait up to PAIR_WINDOW cycles for the partner button, then fire once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cmd   <= 2'b00;
         win   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (press[1] && press[0]) begin
                  state <= ST_FIRE;
                  cmd   <= 2'b11;
               end else if (press[1]) begin
                  state <= ST_WAIT_J;
                  win   <= WIN_INIT;
               end else if (press[0]) begin
                  state <= ST_WAIT_K;
                  win   <= WIN_INIT;
               end
            end
            ST_WAIT_J: begin
               if (press[0]) begin
                  state <= ST_FIRE;
                  cmd   <= 2'b11;
               end else if (win == '0) begin
                  state <= ST_FIRE;
                  cmd   <= 2'b10;
               end else begin
                  win <= win - 1'b1;
               end
            end
            ST_WAIT_K: begin
               if (press[1]) begin
                  state <= ST_FIRE;
                  cmd   <= 2'b11;
               end else if (win == '0) begin
                  state <= ST_FIRE;
                  cmd   <= 2'b01;
               end else begin
                  win <= win - 1'b1;
               end
            end
            ST_FIRE: begin
               // Presses landing here are dropped, not queued.
               state <= ST_IDLE;
               cmd   <= 2'b00;
            end
            default: begin
               state <= ST_IDLE;
               cmd   <= 2'b00;
            end
         endcase
      end
   end

   // Outputs decode purely from registered state and cmd, so they are zero outside FIRE.
   assign j_out     = (state == ST_FIRE) & cmd[1];
   assign k_out     = (state == ST_FIRE) & cmd[0];
   assign cmd_valid = j_out | k_out;
   assign db_j      = db[1];
   assign db_k      = db[0];

endmodule

// File: tb/tb_jk_input_conditioner.sv
// tb/tb_jk_input_conditioner.sv - directed bench for jk_input_conditioner
module tb_jk_input_conditioner;

   logic clk = 1'b0;
   logic rst;
   logic btn_j;
   logic btn_k;
   logic j_out;
   logic k_out;
   logic cmd_valid;
   logic db_j;
   logic db_k;

   int   tests  = 0;
   int   errors = 0;
   int   n10    = 0;
   int   n01    = 0;
   int   n11    = 0;
   int   cv_bad = 0;
   logic q      = 1'b0;

   jk_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .PAIR_WINDOW    (3)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_j    (btn_j),
      .btn_k    (btn_k),
      .j_out    (j_out),
      .k_out    (k_out),
      .cmd_valid(cmd_valid),
      .db_j     (db_j),
      .db_k     (db_k)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Pulse counters and a behavioural JK flip-flop fed by the command outputs.
   always @(negedge clk) begin
      if (j_out === 1'b1 && k_out === 1'b0) n10++;
      if (j_out === 1'b0 && k_out === 1'b1) n01++;
      if (j_out === 1'b1 && k_out === 1'b1) n11++;
      if (cmd_valid !== (j_out | k_out)) cv_bad++;
      if (j_out === 1'b1 && k_out === 1'b0) q = 1'b1;
      else if (j_out === 1'b0 && k_out === 1'b1) q = 1'b0;
      else if (j_out === 1'b1 && k_out === 1'b1) q = ~q;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      n10 = 0;
      n01 = 0;
      n11 = 0;
   endtask

   task automatic settle();
      btn_j = 1'b0;
      btn_k = 1'b0;
      repeat (12) step();
   endtask

   task automatic check_counts(input string tag, input int e10, input int e01, input int e11);
      check({tag, "_n10"}, n10, e10);
      check({tag, "_n01"}, n01, e01);
      check({tag, "_n11"}, n11, e11);
   endtask

   initial begin
      rst   = 1'b1;
      btn_j = 1'b0;
      btn_k = 1'b0;
      #2;
      check("rst_j_out", j_out, 0);
      check("rst_k_out", k_out, 0);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_db_j", db_j, 0);
      check("rst_db_k", db_k, 0);
      repeat (2) step();
      rst = 1'b0;
      repeat (2) step();

      // 1: lone J press, db_j at edge 6, 10 pulse at edge 10 only
      clear_counts();
      btn_j = 1'b1;
      for (int e = 1; e <= 12; e++) begin
         step();
         check("t1_db_j", db_j, (e >= 6) ? 1 : 0);
         check("t1_j_out", j_out, (e == 10) ? 1 : 0);
         check("t1_k_out", k_out, 0);
      end
      settle();
      check_counts("t1", 1, 0, 0);

      // 2: same-cycle pair, 11 pulse at edge 7 only
      clear_counts();
      btn_j = 1'b1;
      btn_k = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         step();
         check("t2_j_out", j_out, (e == 7) ? 1 : 0);
         check("t2_k_out", k_out, (e == 7) ? 1 : 0);
         check("t2_cmd_valid", cmd_valid, (e == 7) ? 1 : 0);
      end
      settle();
      check_counts("t2", 0, 0, 1);

      // 3: K two cycles after J, single 11 pulse at edge 9
      clear_counts();
      btn_j = 1'b1;
      step();
      step();
      btn_k = 1'b1;
      for (int e = 3; e <= 14; e++) begin
         step();
         check("t3_jk", {j_out, k_out}, (e == 9) ? 2'b11 : 2'b00);
      end
      settle();
      check_counts("t3", 0, 0, 1);

      // 4: three-cycle glitches on K never reach db_k
      clear_counts();
      for (int g = 0; g < 5; g++) begin
         btn_k = 1'b1;
         repeat (3) begin
            step();
            check("t4_db_k_hi", db_k, 0);
         end
         btn_k = 1'b0;
         repeat (3) begin
            step();
            check("t4_db_k_lo", db_k, 0);
         end
      end
      repeat (8) begin
         step();
         check("t4_db_k_tail", db_k, 0);
      end
      check_counts("t4", 0, 0, 0);

      // 5: reset during WAIT_J aborts; held button gives one 10 pulse 10 edges after release
      clear_counts();
      btn_j = 1'b1;
      repeat (8) step();
      rst = 1'b1;
      #1;
      check("t5_rst_j_out", j_out, 0);
      check("t5_rst_k_out", k_out, 0);
      check("t5_rst_db_j", db_j, 0);
      check("t5_rst_cmd_valid", cmd_valid, 0);
      step();
      step();
      rst = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         step();
         check("t5_j_out", j_out, (e == 10) ? 1 : 0);
         check("t5_k_out", k_out, 0);
      end
      settle();
      check_counts("t5", 1, 0, 0);

      // 6: drive a JK flip-flop model from Q=0
      clear_counts();
      q = 1'b0;
      btn_j = 1'b1;
      repeat (14) step();
      settle();
      check("t6_q_after_j", q, 1);
      btn_k = 1'b1;
      repeat (14) step();
      settle();
      check("t6_q_after_k", q, 0);
      btn_j = 1'b1;
      btn_k = 1'b1;
      repeat (14) step();
      settle();
      check("t6_q_after_pair", q, 1);
      repeat (100) step();
      check("t6_q_idle", q, 1);
      check_counts("t6", 1, 1, 1);

      check("cmd_valid_decode", cv_bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
